qc_arbiter: RTL
===============

QC_ARBITER -- requirements
Module: qc_arbiter

Interface
REQ-001 Parameter: TMO, 16'd1000, watchdog limit in CLK cycles, valid range 2..65535.
REQ-002 CLK  input  1  rising-edge system clock, sole clock domain.
REQ-003 RST  input  1  reset, synchronous and active-high.
REQ-004 REQA  input  1  piece waiting at feeder conveyor A.
REQ-005 REQB  input  1  piece waiting at feeder conveyor B.
REQ-006 DCE  input  1  piece detected at inspection-cell entry.
REQ-007 POK  input  1  inspection result: piece OK.
REQ-008 PNOK  input  1  inspection result: piece not OK.
REQ-009 DCS  input  1  piece detected at cell exit.
REQ-010 MA  output  1  feeder A motor.
REQ-011 MB  output  1  feeder B motor.
REQ-012 Ms  output  1  exit motor.
REQ-013 GA / GB  output  1 each  grant indicators, one-hot or both 0.
REQ-014 Lok / Lnok  output  1 each  result lamps.
REQ-015 OKCNT / NOKCNT  output  8 each  pieces passed / rejected.
REQ-016 FAULT  output  1  watchdog fault flag.

Function
REQ-017 All outputs SHALL be registered; no combinational path from any input to any output.
REQ-018 FSM states SHALL be IDLE, FEED, INSPECT, EXIT, CLEAR, plus FAULT when TIMEOUT_EN is defined.
REQ-019 IDLE: all motors, grants and lamps 0; on an edge with REQA or REQB high, go to FEED and set the winner's grant and motor at that same edge (1-cycle latency from sampled request).
REQ-020 Arbitration SHALL be round-robin: single requester wins; if both request, the feeder not served last wins; a 1-bit last-served pointer updates on leaving CLEAR.
REQ-021 FEED: granted motor stays 1 until DCE sampled 1; at that edge motor goes 0 and state goes to INSPECT.
REQ-022 Request deassertion after grant SHALL be ignored; the cycle completes.
REQ-023 INSPECT: on POK or PNOK sampled 1, set Lok or Lnok, set Ms=1, go to EXIT; POK SHALL win if both high in the same cycle.
REQ-024 OKCNT/NOKCNT SHALL increment by 1 at the INSPECT-exit edge and saturate at 255.
REQ-025 EXIT: Ms stays 1 until DCS sampled 1; then Ms=0, go to CLEAR.
REQ-026 CLEAR: wait for DCS sampled 0; then clear Lok/Lnok and grants, update pointer, go to IDLE.
REQ-027 Grant SHALL remain asserted from FEED entry through CLEAR exit.
REQ-028 Unreachable state encodings SHALL return to IDLE on the next edge with all outputs 0.

Reset
REQ-029 RST high at a CLK edge SHALL force IDLE, all motors/grants/lamps/FAULT 0, both counters 0, pointer = B (A wins first tie), watchdog 0.
REQ-030 Reset mid-operation SHALL abort the cycle with no counter update; RST has priority over every transition.

Configuration
REQ-031 Macro QC_ARBITER_TIMEOUT_EN defined: a 16-bit watchdog clears on every state change, counts each cycle in FEED, INSPECT, EXIT; on reaching TMO-1, next edge enters FAULT.
REQ-032 FAULT: all motors 0, grants and lamps held, FAULT=1, counters frozen; exit only by RST.
REQ-033 Macro undefined: no watchdog or FAULT state, FAULT tied 0, FSM waits indefinitely.

Verification
REQ-034 Reset, REQA=1 one cycle -> next edge GA=1, MA=1; DCE=1 -> MA=0; POK=1 -> Lok=1, Ms=1, OKCNT=1; DCS 1 then 0 -> IDLE, all 0.
REQ-035 REQA=REQB=1 held for 3 cycles -> grants A, B, A in order; NOKCNT and OKCNT match results applied.
REQ-036 POK=PNOK=1 same cycle in INSPECT -> Lok=1, Lnok=0, only OKCNT increments.
REQ-037 260 OK pieces -> OKCNT stops at 255; NOKCNT stays 0.
REQ-038 RST pulse during EXIT with Ms=1 -> next edge Ms=0, GA=GB=0, counters 0, state IDLE.
REQ-039 TIMEOUT_EN, TMO=10, no DCE in FEED -> after 10 cycles FAULT=1, MA=0, GA still 1; RST clears FAULT.

Source files
------------

// File: rtl/qc_arbiter.sv
// qc_arbiter -- round-robin feeder arbiter for a single inspection cell.
//
// Two feeder conveyors (A, B) compete for one inspection cell. A piece is
// fed, inspected, driven out, and the exit sensor must clear before the
// next piece is admitted. Pass/reject totals are kept in saturating
// 8-bit counters.
//
// Ports:
//   CLK            rising-edge clock
//   RST            synchronous active-high reset
//   REQA/REQB      piece waiting at feeder A / B
//   DCE/DCS        piece at cell entry / cell exit
//   POK/PNOK       inspection verdict (POK wins when both are high)
//   MA/MB/Ms       feeder A, feeder B and exit motors
//   GA/GB          grant indicators (one-hot or idle)
//   Lok/Lnok       result lamps
//   OKCNT/NOKCNT   saturating pass/reject counters
//   FAULT          watchdog fault flag
//
// Optional feature: define QC_ARBITER_TIMEOUT_EN to add a watchdog that
// moves the FSM to a latched FAULT state when FEED, INSPECT or EXIT lasts
// TMO cycles. Without it, FAULT is tied to 0 and the FSM waits forever.
// All outputs come straight from flops.

module qc_arbiter #(
    parameter logic [15:0] TMO = 16'd1000
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       REQA,
    input  logic       REQB,
    input  logic       DCE,
    input  logic       POK,
    input  logic       PNOK,
    input  logic       DCS,
    output logic       MA,
    output logic       MB,
    output logic       Ms,
    output logic       GA,
    output logic       GB,
    output logic       Lok,
    output logic       Lnok,
    output logic [7:0] OKCNT,
    output logic [7:0] NOKCNT,
    output logic       FAULT
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FEED    = 3'd1,
        S_INSPECT = 3'd2,
        S_EXIT    = 3'd3,
        S_CLEAR   = 3'd4
`ifdef QC_ARBITER_TIMEOUT_EN
        ,S_FAULT  = 3'd5
`endif
    } state_t;

    state_t     state, state_n;
    logic       ga, gb, ma, mb, ms, lok, lnok, flt;
    logic       ga_n, gb_n, ma_n, mb_n, ms_n, lok_n, lnok_n, flt_n;
    logic [7:0] okcnt, nokcnt, okcnt_n, nokcnt_n;
    // Last-served feeder: 0 = A, 1 = B. Reset to B so A wins the first tie.
    logic       last_b, last_b_n;
    logic       pick_a;

`ifdef QC_ARBITER_TIMEOUT_EN
    logic [15:0] wdog, wdog_n;
    logic        timed;
    logic        tmo_hit;
`else
    logic        unused_tmo;
    assign unused_tmo = ^TMO;
`endif

    // A wins when it is the only requester, or on a tie when B went last.
    assign pick_a = REQA && (!REQB || last_b);

    always_comb begin
        state_n  = state;
        ga_n     = ga;
        gb_n     = gb;
        ma_n     = ma;
        mb_n     = mb;
        ms_n     = ms;
        lok_n    = lok;
        lnok_n   = lnok;
        flt_n    = flt;
        okcnt_n  = okcnt;
        nokcnt_n = nokcnt;
        last_b_n = last_b;

        case (state)
            S_IDLE: begin
                if (REQA || REQB) begin
                    state_n = S_FEED;
                    ga_n    = pick_a;
                    ma_n    = pick_a;
                    gb_n    = !pick_a;
                    mb_n    = !pick_a;
                end
            end
            S_FEED: begin
                if (DCE) begin
                    state_n = S_INSPECT;
                    ma_n    = 1'b0;
                    mb_n    = 1'b0;
                end
            end
            S_INSPECT: begin
                if (POK) begin
                    state_n = S_EXIT;
                    lok_n   = 1'b1;
                    ms_n    = 1'b1;
                    if (okcnt != 8'hFF) okcnt_n = okcnt + 8'd1;
                end else if (PNOK) begin
                    state_n = S_EXIT;
                    lnok_n  = 1'b1;
                    ms_n    = 1'b1;
                    if (nokcnt != 8'hFF) nokcnt_n = nokcnt + 8'd1;
                end
            end
            S_EXIT: begin
                if (DCS) begin
                    state_n = S_CLEAR;
                    ms_n    = 1'b0;
                end
            end
            S_CLEAR: begin
                // Piece must fully leave the exit sensor before re-arming.
                if (!DCS) begin
                    state_n  = S_IDLE;
                    lok_n    = 1'b0;
                    lnok_n   = 1'b0;
                    ga_n     = 1'b0;
                    gb_n     = 1'b0;
                    last_b_n = gb;
                end
            end
`ifdef QC_ARBITER_TIMEOUT_EN
            S_FAULT: begin
                // Latched until reset; hold grants, lamps and counters.
                ma_n  = 1'b0;
                mb_n  = 1'b0;
                ms_n  = 1'b0;
                flt_n = 1'b1;
            end
`endif
            default: begin
                state_n  = S_IDLE;
                ga_n     = 1'b0;
                gb_n     = 1'b0;
                ma_n     = 1'b0;
                mb_n     = 1'b0;
                ms_n     = 1'b0;
                lok_n    = 1'b0;
                lnok_n   = 1'b0;
                flt_n    = 1'b0;
                okcnt_n  = 8'd0;
                nokcnt_n = 8'd0;
            end
        endcase

`ifdef QC_ARBITER_TIMEOUT_EN
        // Timeout overrides any same-cycle normal transition.
        if (tmo_hit) begin
            state_n  = S_FAULT;
            ma_n     = 1'b0;
            mb_n     = 1'b0;
            ms_n     = 1'b0;
            flt_n    = 1'b1;
            ga_n     = ga;
            gb_n     = gb;
            lok_n    = lok;
            lnok_n   = lnok;
            okcnt_n  = okcnt;
            nokcnt_n = nokcnt;
            last_b_n = last_b;
        end
`endif
    end

`ifdef QC_ARBITER_TIMEOUT_EN
    assign timed   = (state == S_FEED) || (state == S_INSPECT) || (state == S_EXIT);
    assign tmo_hit = timed && (wdog == TMO - 16'd1);

    always_comb begin
        wdog_n = 16'd0;
        if (timed && (state_n == state)) wdog_n = wdog + 16'd1;
    end

    always_ff @(posedge CLK) begin
        if (RST) wdog <= 16'd0;
        else     wdog <= wdog_n;
    end
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            state  <= S_IDLE;
            ga     <= 1'b0;
            gb     <= 1'b0;
            ma     <= 1'b0;
            mb     <= 1'b0;
            ms     <= 1'b0;
            lok    <= 1'b0;
            lnok   <= 1'b0;
            flt    <= 1'b0;
            okcnt  <= 8'd0;
            nokcnt <= 8'd0;
            last_b <= 1'b1;
        end else begin
            state  <= state_n;
            ga     <= ga_n;
            gb     <= gb_n;
            ma     <= ma_n;
            mb     <= mb_n;
            ms     <= ms_n;
            lok    <= lok_n;
            lnok   <= lnok_n;
            flt    <= flt_n;
            okcnt  <= okcnt_n;
            nokcnt <= nokcnt_n;
            last_b <= last_b_n;
        end
    end

    assign GA     = ga;
    assign GB     = gb;
    assign MA     = ma;
    assign MB     = mb;
    assign Ms     = ms;
    assign Lok    = lok;
    assign Lnok   = lnok;
    assign FAULT  = flt;
    assign OKCNT  = okcnt;
    assign NOKCNT = nokcnt;

endmodule
